hasti_interconnect: RTL

HASTI_INTERCONNECT -- requirements
Module: hasti_interconnect

---
 rtl/hasti_interconnect_pkg.sv | 39 +++
 rtl/hasti_interconnect_if.sv | 41 ++++
 rtl/hasti_default_slave.sv | 94 +++++++++
 rtl/hasti_interconnect.sv | 116 +++++++++++
 4 files changed

// File: rtl/hasti_interconnect_pkg.sv
// Shared AHB-Lite types for the interconnect: transfer/response encodings,
// default-slave states and the address-region helper used by the decoder.
package pk_hasti;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

    localparam int unsigned MAX_SLV = 8;

    // One decode window; an address is outside every window when it lands in the default region.
    typedef struct packed {
        logic [31:0] base;
        logic [31:0] mask;
    } region_t;

    function automatic logic region_hit(input logic [31:0] addr, input region_t r);
        return (addr & r.mask) == r.base;
    endfunction

    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/hasti_interconnect_if.sv
// AHB-Lite bundles as seen from the interconnect: modport f is the fabric side
// of the master link and of each slave link.
interface if_hasti_master_io;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport f (
        input  haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
        output hrdata, hready, hresp
    );
endinterface

interface if_hasti_slave_io;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        hsel;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;

    modport f (
        output haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata, hsel, hready,
        input  hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/hasti_default_slave.sv
// Default slave: answers unmapped active transfers with a two-cycle ERROR and
// keeps a sticky record of the last offending address plus a saturating count.
//
// state   | meaning
// DS_IDLE | no error pending; OKAY, zero wait
// DS_ERR1 | first ERROR cycle, bus stalled
// DS_ERR2 | second ERROR cycle, bus ready; may chain into another error
module hasti_default_slave
    import pk_hasti::*;
#(
    parameter int ERRCNT_W = 8
) (
    input  logic                hclk,
    input  logic                hresetn,
    input  logic                hready,
    input  logic                any_hsel,
    input  logic [1:0]          htrans,
    input  logic [31:0]         haddr,
    input  logic                err_clr,
    output logic                ds_hready,
    output logic                ds_hresp,
    output logic                err_valid,
    output logic [31:0]         err_addr,
    output logic [ERRCNT_W-1:0] err_cnt
);

    ds_state_t state;
    logic      err_fire;

    assign err_fire = hready && !any_hsel && trans_active(htrans);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= DS_IDLE;
            ds_hready <= 1'b1;
            ds_hresp  <= HRESP_OKAY;
        end else begin
            case (state)
                DS_IDLE: begin
                    if (err_fire) begin
                        state     <= DS_ERR1;
                        ds_hready <= 1'b0;
                        ds_hresp  <= HRESP_ERROR;
                    end else begin
                        ds_hready <= 1'b1;
                        ds_hresp  <= HRESP_OKAY;
                    end
                end
                DS_ERR1: begin
                    state     <= DS_ERR2;
                    ds_hready <= 1'b1;
                    ds_hresp  <= HRESP_ERROR;
                end
                DS_ERR2: begin
                    if (err_fire) begin
                        state     <= DS_ERR1;
                        ds_hready <= 1'b0;
                        ds_hresp  <= HRESP_ERROR;
                    end else begin
                        state     <= DS_IDLE;
                        ds_hready <= 1'b1;
                        ds_hresp  <= HRESP_OKAY;
                    end
                end
                default: begin
                    state     <= DS_IDLE;
                    ds_hready <= 1'b1;
                    ds_hresp  <= HRESP_OKAY;
                end
            endcase
        end
    end

    // A new error outranks a simultaneous clear so no fault is ever lost.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            err_valid <= 1'b0;
            err_addr  <= 32'h0;
            err_cnt   <= '0;
        end else if (err_fire) begin
            err_valid <= 1'b1;
            err_addr  <= haddr;
            if (err_clr)
                err_cnt <= {{(ERRCNT_W-1){1'b0}}, 1'b1};
            else if (err_cnt != {ERRCNT_W{1'b1}})
                err_cnt <= err_cnt + 1'b1;
        end else if (err_clr) begin
            err_valid <= 1'b0;
            err_addr  <= 32'h0;
            err_cnt   <= '0;
        end
    end

endmodule

// File: rtl/hasti_interconnect.sv
// Single-master AHB-Lite interconnect: address decode, data-phase select
// register and response mux, with a default slave covering unmapped space.
module hasti_interconnect
    import pk_hasti::*;
#(
    parameter int          NSLV = 2,
    parameter logic [31:0] SLV_BASE [NSLV] = '{32'h0000_0000, 32'h2000_0000},
    parameter logic [31:0] SLV_MASK [NSLV] = '{32'hFFFF_FC00, 32'hFFFF_FC00},
    parameter int          ERRCNT_W = 8
) (
    input  logic                hclk,
    input  logic                hresetn,
    if_hasti_master_io.f        m,
    if_hasti_slave_io.f         s [NSLV],
    input  logic                err_clr,
    output logic                err_valid,
    output logic [31:0]         err_addr,
    output logic [ERRCNT_W-1:0] err_cnt
);

    if (NSLV < 1 || NSLV > MAX_SLV) begin : g_bad_nslv
        $error("hasti_interconnect: NSLV must be 1..8");
    end

    logic [NSLV-1:0] slv_hit;
    logic [NSLV-1:0] hsel;
    logic [NSLV:0]   sel_r;
    logic [31:0]     slv_rdata [NSLV];
    logic [NSLV-1:0] slv_readyout;
    logic [NSLV-1:0] slv_resp;
    logic            hready;
    logic            ds_hready;
    logic            ds_hresp;
    logic [31:0]     hrdata_mux;
    logic            hresp_mux;

    for (genvar i = 0; i < NSLV; i++) begin : g_slv
        localparam region_t REGION = '{base: SLV_BASE[i], mask: SLV_MASK[i]};

        if ((SLV_BASE[i] & ~SLV_MASK[i]) != 32'h0) begin : g_bad_align
            $error("hasti_interconnect: SLV_BASE has bits outside SLV_MASK");
        end

        assign slv_hit[i]      = region_hit(m.haddr, REGION);
        assign s[i].haddr      = m.haddr;
        assign s[i].hwrite     = m.hwrite;
        assign s[i].hsize      = m.hsize;
        assign s[i].hburst     = m.hburst;
        assign s[i].hprot      = m.hprot;
        assign s[i].htrans     = m.htrans;
        assign s[i].hmastlock  = m.hmastlock;
        assign s[i].hwdata     = m.hwdata;
        assign s[i].hsel       = hsel[i];
        assign s[i].hready     = hready;
        assign slv_rdata[i]    = s[i].hrdata;
        assign slv_readyout[i] = s[i].hreadyout;
        assign slv_resp[i]     = s[i].hresp;
    end

    // Overlapping windows resolve to the lowest-numbered slave.
    always_comb begin
        logic found;
        found = 1'b0;
        hsel  = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (!found && slv_hit[i]) begin
                hsel[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)
            sel_r <= {1'b1, {NSLV{1'b0}}};
        else if (hready)
            sel_r <= {~|hsel, hsel};
    end

    always_comb begin
        hrdata_mux = 32'h0;
        hresp_mux  = ds_hresp;
        hready     = ds_hready;
        if (!sel_r[NSLV]) begin
            for (int i = 0; i < NSLV; i++) begin
                if (sel_r[i]) begin
                    hrdata_mux = slv_rdata[i];
                    hresp_mux  = slv_resp[i];
                    hready     = slv_readyout[i];
                end
            end
        end
    end

    assign m.hrdata = hrdata_mux;
    assign m.hresp  = hresp_mux;
    assign m.hready = hready;

    hasti_default_slave #(
        .ERRCNT_W (ERRCNT_W)
    ) u_default_slave (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hready    (hready),
        .any_hsel  (|hsel),
        .htrans    (m.htrans),
        .haddr     (m.haddr),
        .err_clr   (err_clr),
        .ds_hready (ds_hready),
        .ds_hresp  (ds_hresp),
        .err_valid (err_valid),
        .err_addr  (err_addr),
        .err_cnt   (err_cnt)
    );

endmodule
